branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64: number of direct-mapped entries; power of two, at least 2.
REQ-002 SHALL have parameter CTR_W, default 2: saturating-counter width; at least 1.
REQ-003 SHALL have parameter TAG_W, default 8: stored tag width; log2(ENTRIES)+2+TAG_W SHALL NOT exceed 32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port bp_enable, input, 1 bit: predictor enable.
REQ-007 SHALL have port clear, input, 1 bit: invalidate all entries.
REQ-008 SHALL have port if_valid, input, 1 bit: lookup request is valid this cycle.
REQ-009 SHALL have port if_pc, input, 32 bits: fetch PC to look up.
REQ-010 SHALL have port if_hit, output, 1 bit: lookup matched a valid entry.
REQ-011 SHALL have port if_guess, output, 1 bit: predicted taken.
REQ-012 SHALL have port ex_upd_valid, input, 1 bit: a resolved branch is presented this cycle.
REQ-013 SHALL have port ex_upd_pc, input, 32 bits: PC of the resolved branch.
REQ-014 SHALL have port ex_upd_taken, input, 1 bit: actual branch outcome.
REQ-015 SHALL have port ex_upd_mispred, input, 1 bit: EX reports a misprediction.
REQ-016 SHALL have ports perf_lookups, perf_updates and perf_mispred, each output, 32 bits: performance counters.

Function
REQ-017 SHALL derive the index as pc[IDX_W+1:2] and the tag as pc[IDX_W+TAG_W+1:IDX_W+2], where IDX_W = log2(ENTRIES).
REQ-018 SHALL hold, per entry, one valid bit, one TAG_W-bit tag and one CTR_W-bit counter, all in flops.
REQ-019 SHALL drive if_hit combinationally as if_valid AND bp_enable AND entry valid AND tag equal.
REQ-020 SHALL drive if_guess as if_hit AND the counter MSB; zero-latency lookup from current state.
REQ-021 SHALL, on ex_upd_valid with bp_enable high and a tag hit, increment the counter when taken and decrement it when not taken, saturating at all-ones and zero.
REQ-022 SHALL, on ex_upd_valid with bp_enable high and a miss, allocate the entry: valid=1, new tag, counter = weakly taken (MSB=1, rest 0) if taken, else weakly not-taken (MSB=0, rest 1).
REQ-023 SHALL make an update visible to lookups on the next cycle; a same-cycle lookup of the same index sees the old state (no bypass).
REQ-024 SHALL ignore updates while bp_enable is low; state is retained.
REQ-025 SHALL, on clear, zero all valid bits in one cycle; clear wins over a simultaneous update.
REQ-026 SHALL let a conflicting PC (same index, different tag) evict the entry on update.

Reset
REQ-027 SHALL, on asserted rst, immediately and asynchronously zero all valid bits, tags and perf counters and set all counters to weakly not-taken; if_hit and if_guess are then 0.
REQ-028 SHALL, when rst asserts mid-update, discard that update.

Configuration
REQ-029 SHALL, with BP_PERF_EN defined: perf_lookups increments on every cycle with if_valid, perf_updates on each accepted update, and perf_mispred on each accepted update with ex_upd_mispred; each counter wraps from 0xFFFFFFFF to 0 and is not cleared by clear.
REQ-030 SHALL, without BP_PERF_EN, tie all perf outputs to 0 and instantiate no counter flops.

Structure
REQ-031 SHALL place the weak-taken and weak-not-taken init functions and the index/tag extraction functions in package bp_pkg.
REQ-032 SHALL implement the per-entry saturating update as sub-module bp_sat_counter, parametrised by CTR_W.

Verification
REQ-033 SHALL check reset then lookup 0x4000_0010 -> if_hit=0, if_guess=0.
REQ-034 SHALL check an update at 0x4000_0010 with taken=1, then a next-cycle lookup -> if_hit=1, if_guess=1 (counter 2'b10).
REQ-035 SHALL check four not-taken updates at that PC -> counter 2'b00; a fifth update holds 2'b00 and if_guess=0.
REQ-036 SHALL check, with ENTRIES=64, an update at 0x4000_0110 (same index, new tag) -> a lookup of 0x4000_0010 misses.
REQ-037 SHALL check clear asserted together with an update -> all lookups miss on the next cycle.
REQ-038 SHALL check, with BP_PERF_EN, 10 lookups, 3 updates and 1 mispredict -> counters read 10/3/1; when preset to 0xFFFFFFFF, one lookup wraps perf_lookups to 0.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared helpers for the branch predictor: PC index/tag
//               extraction and counter initialisation values.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

   // Entry index: the word-aligned PC bits just above the byte offset
   function automatic logic [31:0] bp_pc_index(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Stored tag: the PC bits immediately above the index field
   function automatic logic [31:0] bp_pc_tag(input logic [31:0] pc, input int idx_w,
                                             input int tag_w);
      return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
   endfunction

   // Weakly taken: MSB set, all lower bits clear
   function automatic logic [31:0] bp_weak_taken(input int ctr_w);
      return 32'd1 << (ctr_w - 1);
   endfunction

   // Weakly not-taken: MSB clear, all lower bits set
   function automatic logic [31:0] bp_weak_not_taken(input int ctr_w);
      return (32'd1 << (ctr_w - 1)) - 32'd1;
   endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter
// Description : Combinational next-state for one CTR_W-bit saturating
//               up/down counter (up on taken, down on not-taken).
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_in,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_out
);

   localparam logic [CTR_W-1:0] c_ctr_max = '1;
   localparam logic [CTR_W-1:0] c_ctr_min = '0;
   localparam logic [CTR_W-1:0] c_ctr_one = CTR_W'(1);

   // Step toward the outcome, holding at either end of the range
   always_comb begin
      ctr_out = ctr_in;
      if (taken) begin
         if (ctr_in != c_ctr_max) begin
            ctr_out = ctr_in + c_ctr_one;
         end
      end else begin
         if (ctr_in != c_ctr_min) begin
            ctr_out = ctr_in - c_ctr_one;
         end
      end
   end

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped, tagged branch predictor with per-entry
//               saturating counters. Zero-latency lookup from current
//               state; updates from EX land on the next rising edge.
//               Optional performance counters enabled by BP_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bp_enable,
   input  logic        clear,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   output logic        if_hit,
   output logic        if_guess,
   input  logic        ex_upd_valid,
   input  logic [31:0] ex_upd_pc,
   input  logic        ex_upd_taken,
   input  logic        ex_upd_mispred,
   output logic [31:0] perf_lookups,
   output logic [31:0] perf_updates,
   output logic [31:0] perf_mispred
);

   localparam int c_idx_w = $clog2(ENTRIES);

   localparam logic [CTR_W-1:0] c_weak_t  = CTR_W'(bp_weak_taken(CTR_W));
   localparam logic [CTR_W-1:0] c_weak_nt = CTR_W'(bp_weak_not_taken(CTR_W));

   // Entry storage
   logic               r_valid [ENTRIES];
   logic [TAG_W-1:0]   r_tag   [ENTRIES];
   logic [CTR_W-1:0]   r_ctr   [ENTRIES];

   // Lookup side
   logic [c_idx_w-1:0] w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;

   // Update side
   logic [c_idx_w-1:0] w_upd_idx;
   logic [TAG_W-1:0]   w_upd_tag;
   logic               w_upd_hit;
   logic               w_upd_fire;
   logic [CTR_W-1:0]   w_ctr_sat;
   logic [CTR_W-1:0]   w_ctr_next;

   assign w_if_idx  = c_idx_w'(bp_pc_index(if_pc, c_idx_w));
   assign w_if_tag  = TAG_W'(bp_pc_tag(if_pc, c_idx_w, TAG_W));
   assign w_upd_idx = c_idx_w'(bp_pc_index(ex_upd_pc, c_idx_w));
   assign w_upd_tag = TAG_W'(bp_pc_tag(ex_upd_pc, c_idx_w, TAG_W));

   // Lookup reads current state only; an update this cycle is not bypassed
   assign w_if_hit = if_valid & bp_enable & r_valid[w_if_idx]
                   & (r_tag[w_if_idx] == w_if_tag);
   assign if_hit   = w_if_hit;
   assign if_guess = w_if_hit & r_ctr[w_if_idx][CTR_W-1];

   // An update is accepted only when enabled and not overridden by clear
   assign w_upd_fire = ex_upd_valid & bp_enable & ~clear;
   assign w_upd_hit  = r_valid[w_upd_idx] & (r_tag[w_upd_idx] == w_upd_tag);

   bp_sat_counter #(
      .CTR_W   (CTR_W)
   ) u_sat_counter (
      .ctr_in  (r_ctr[w_upd_idx]),
      .taken   (ex_upd_taken),
      .ctr_out (w_ctr_sat)
   );

   // Hit trains the existing counter; a miss (or tag conflict) reallocates
   assign w_ctr_next = w_upd_hit    ? w_ctr_sat :
                       ex_upd_taken ? c_weak_t  : c_weak_nt;

   // Entry table: async reset, single-cycle clear, otherwise one write per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_tag[i]   <= '0;
            r_ctr[i]   <= c_weak_nt;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (w_upd_fire) begin
         r_valid[w_upd_idx] <= 1'b1;
         r_tag[w_upd_idx]   <= w_upd_tag;
         r_ctr[w_upd_idx]   <= w_ctr_next;
      end
   end

`ifdef BP_PERF_EN
   logic [31:0] r_perf_lookups;
   logic [31:0] r_perf_updates;
   logic [31:0] r_perf_mispred;

   // Free-running event counters; wrap naturally and ignore clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_lookups <= '0;
         r_perf_updates <= '0;
         r_perf_mispred <= '0;
      end else begin
         if (if_valid) begin
            r_perf_lookups <= r_perf_lookups + 32'd1;
         end
         if (w_upd_fire) begin
            r_perf_updates <= r_perf_updates + 32'd1;
            if (ex_upd_mispred) begin
               r_perf_mispred <= r_perf_mispred + 32'd1;
            end
         end
      end
   end

   assign perf_lookups = r_perf_lookups;
   assign perf_updates = r_perf_updates;
   assign perf_mispred = r_perf_mispred;
`else
   logic w_unused_mispred;

   // Counters absent: outputs tied off, mispredict flag not needed
   assign w_unused_mispred = ex_upd_mispred;
   assign perf_lookups     = '0;
   assign perf_updates     = '0;
   assign perf_mispred     = '0;
`endif

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench for branch_predictor. Directed steps
//               followed by a randomized phase, checked against a table
//               model kept here in plain integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   localparam int ENTRIES = 64;
   localparam int CTR_W   = 2;
   localparam int TAG_W   = 8;
   localparam int CTR_MAX = (1 << CTR_W) - 1;
   localparam int CTR_MID = 1 << (CTR_W - 1);
`ifdef BP_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        bp_enable;
   logic        clear;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        if_hit;
   logic        if_guess;
   logic        ex_upd_valid;
   logic [31:0] ex_upd_pc;
   logic        ex_upd_taken;
   logic        ex_upd_mispred;
   logic [31:0] perf_lookups;
   logic [31:0] perf_updates;
   logic [31:0] perf_mispred;

   branch_predictor #(
      .ENTRIES        (ENTRIES),
      .CTR_W          (CTR_W),
      .TAG_W          (TAG_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bp_enable      (bp_enable),
      .clear          (clear),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_hit         (if_hit),
      .if_guess       (if_guess),
      .ex_upd_valid   (ex_upd_valid),
      .ex_upd_pc      (ex_upd_pc),
      .ex_upd_taken   (ex_upd_taken),
      .ex_upd_mispred (ex_upd_mispred),
      .perf_lookups   (perf_lookups),
      .perf_updates   (perf_updates),
      .perf_mispred   (perf_mispred)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: one record per entry plus event totals
   bit          m_valid [ENTRIES];
   int          m_tag   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_look;
   logic [31:0] m_upd;
   logic [31:0] m_mis;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc / (4 * ENTRIES)) % (1 << TAG_W));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_ctr[i]   = CTR_MID - 1;
      end
      m_look = '0;
      m_upd  = '0;
      m_mis  = '0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check the combinational lookup and perf outputs,
   // then let the edge happen and advance the model.
   task automatic step(input bit v, input logic [31:0] pc,
                       input bit uv, input logic [31:0] upc, input bit tk, input bit mp,
                       input bit en, input bit clr);
      int  li;
      int  ui;
      bit  eh;
      bit  eg;
      @(negedge clk);
      if_valid       = v;
      if_pc          = pc;
      ex_upd_valid   = uv;
      ex_upd_pc      = upc;
      ex_upd_taken   = tk;
      ex_upd_mispred = mp;
      bp_enable      = en;
      clear          = clr;
      #1;
      li = idx_of(pc);
      eh = v && en && m_valid[li] && (m_tag[li] == tag_of(pc));
      eg = eh && (m_ctr[li] >= CTR_MID);
      check("if_hit",   {31'd0, if_hit},   {31'd0, eh});
      check("if_guess", {31'd0, if_guess}, {31'd0, eg});
      check("perf_lookups", perf_lookups, PERF ? m_look : 32'd0);
      check("perf_updates", perf_updates, PERF ? m_upd  : 32'd0);
      check("perf_mispred", perf_mispred, PERF ? m_mis  : 32'd0);
      @(posedge clk);
      if (v) m_look = m_look + 32'd1;
      if (clr) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (uv && en) begin
         m_upd = m_upd + 32'd1;
         if (mp) m_mis = m_mis + 32'd1;
         ui = idx_of(upc);
         if (m_valid[ui] && m_tag[ui] == tag_of(upc)) begin
            if (tk) m_ctr[ui] = (m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX;
            else    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
         end else begin
            m_valid[ui] = 1'b1;
            m_tag[ui]   = tag_of(upc);
            m_ctr[ui]   = tk ? CTR_MID : CTR_MID - 1;
         end
      end
   endtask

   task automatic lookup(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic update(input logic [31:0] upc, input bit tk, input bit mp);
      step(1'b0, 32'd0, 1'b1, upc, tk, mp, 1'b1, 1'b0);
   endtask

   // Assert reset asynchronously, check outputs drop at once, then release
   task automatic apply_reset();
      if_valid  = 1'b1;
      if_pc     = 32'h4000_0010;
      bp_enable = 1'b1;
      rst       = 1'b1;
      #1;
      check("rst_if_hit",   {31'd0, if_hit},   32'd0);
      check("rst_if_guess", {31'd0, if_guess}, 32'd0);
      check("rst_perf_lookups", perf_lookups, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rpc;
      logic [31:0] rupc;
      rst            = 1'b1;
      bp_enable      = 1'b0;
      clear          = 1'b0;
      if_valid       = 1'b0;
      if_pc          = '0;
      ex_upd_valid   = 1'b0;
      ex_upd_pc      = '0;
      ex_upd_taken   = 1'b0;
      ex_upd_mispred = 1'b0;
      model_reset();
      #2;

      // Reset state and a cold lookup
      apply_reset();
      lookup(32'h4000_0010);

      // Allocate taken; same-cycle lookup sees the old (empty) entry
      step(1'b1, 32'h4000_0010, 1'b1, 32'h4000_0010, 1'b1, 1'b0, 1'b1, 1'b0);
      lookup(32'h4000_0010);
      check("ctr_after_alloc_taken", 32'(dut.r_ctr[4]), 32'd2);

      // Train down to strongly not-taken, then saturate
      for (int k = 0; k < 4; k++) update(32'h4000_0010, 1'b0, 1'b0);
      check("ctr_after_4_nt", 32'(dut.r_ctr[4]), 32'd0);
      update(32'h4000_0010, 1'b0, 1'b0);
      check("ctr_saturated_low", 32'(dut.r_ctr[4]), 32'd0);
      lookup(32'h4000_0010);

      // Saturate high as well
      for (int k = 0; k < 5; k++) update(32'h4000_0010, 1'b1, 1'b0);
      check("ctr_saturated_high", 32'(dut.r_ctr[4]), 32'd3);
      lookup(32'h4000_0010);

      // Conflicting tag evicts the entry
      update(32'h4000_0110, 1'b0, 1'b0);
      lookup(32'h4000_0010);
      lookup(32'h4000_0110);

      // Disabled predictor: no hits, updates dropped, state kept
      step(1'b1, 32'h4000_0110, 1'b1, 32'h4000_0110, 1'b1, 1'b1, 1'b0, 1'b0);
      lookup(32'h4000_0110);
      check("ctr_kept_when_disabled", 32'(dut.r_ctr[4]), 32'd1);

      // Clear together with an update: everything misses afterwards
      update(32'h4000_0020, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 32'h4000_0030, 1'b1, 1'b0, 1'b1, 1'b1);
      lookup(32'h4000_0110);
      lookup(32'h4000_0020);
      lookup(32'h4000_0030);

      // Reset asserted between edges while an update is being presented
      @(negedge clk);
      if_valid = 1'b0; ex_upd_valid = 1'b1; ex_upd_pc = 32'h4000_0210;
      ex_upd_taken = 1'b1; bp_enable = 1'b1; clear = 1'b0;
      #2;
      ex_upd_valid = 1'b0;
      apply_reset();
      lookup(32'h4000_0210);

      // Perf event counts from a fresh reset
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 32'h4000_0040 + 32'(k * 4), (k < 3), 32'h4000_0080 + 32'(k * 4),
              1'b1, (k == 1), 1'b1, 1'b0);
      end
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("perf_lookups_10", perf_lookups, PERF ? 32'd10 : 32'd0);
      check("perf_updates_3",  perf_updates, PERF ? 32'd3  : 32'd0);
      check("perf_mispred_1",  perf_mispred, PERF ? 32'd1  : 32'd0);

`ifdef BP_PERF_EN
      // Preset the lookup counter to its maximum and watch it wrap
      force dut.r_perf_lookups = 32'hFFFF_FFFF;
      #1;
      release dut.r_perf_lookups;
      m_look = 32'hFFFF_FFFF;
      lookup(32'h4000_0040);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("perf_lookups_wrap", perf_lookups, 32'd0);
`endif

      // Randomized traffic over a small PC pool to force hits and conflicts
      for (int k = 0; k < 400; k++) begin
         rpc  = 32'h4000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 2) << 8);
         rupc = 32'h4000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 2) << 8);
         step($urandom_range(0, 3) != 0, rpc,
              $urandom_range(0, 1) == 1, rupc,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety bound on total run time
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule : tb_branch_predictor
`default_nettype wire
